key_debounce: RTL and testbench

Upstream conditioning stage for mechanical key or switch inputs. It takes a raw, asynchronous, bouncing pin and produces a clean, synchronised, debounced level. That level feeds the edge_detect stage's din input.
The block also emits its own single-cycle press and release pulses, so simple consumers can bypass edge detection entirely. Internally it is a 2-FF synchroniser, a 4-state debounce FSM and a stability counter.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_sync.sv | 33 +++
 rtl/key_debounce.sv | 131 +++++++++++++
 tb/tb_key_debounce.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debounce block.
// Contents: the debounce FSM state encoding and the default filter length.
package key_debounce_pkg;

    // 20 ms at 50 MHz
    localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_FILT = 2'd3
    } deb_state_e;

endpackage

// File: rtl/key_debounce_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is a parameter, so the flops can come out of reset
// holding the input's idle level. Shared by other async inputs.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronised output (two clk edges of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounce for a mechanical key or switch pin.
// Synchronises the raw pin, normalises its polarity (1 = pressed) and only
// accepts a level change once the synchronised pin has stayed at the new
// level long enough. Emits registered one-cycle press/release pulses.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   key_in      - raw pin, asynchronous, may bounce
//   key_level   - debounced level, 1 = pressed
//   key_press   - one-cycle pulse when a press is accepted
//   key_release - one-cycle pulse when a release is accepted
//
// state        | meaning
// IDLE         | released and stable
// PRESS_FILT   | pin reads pressed, waiting for it to stay stable
// PRESSED      | pressed and stable
// RELEASE_FILT | pin reads released, waiting for it to stay stable
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter bit          ACTIVE_LOW = 1'b1,
    localparam int unsigned CNT_W     = $clog2(DEB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             key_sync;
    logic             key_s;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchroniser idles at the released pin level so reset release
    // never looks like a press.
    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_in),
        .q_o   (key_sync)
    );

    assign key_s = key_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Every exit from a filter state clears the counter, so it never
    // needs to saturate.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_s) begin
                    state_d = PRESS_FILT;
                end
            end
            PRESS_FILT: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!key_s) begin
                    state_d = RELEASE_FILT;
                end
            end
            RELEASE_FILT: begin
                if (key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    logic clk;
    logic rst_a_n, rst_b_n;
    logic key_a, key_b;
    logic lvl_a, prs_a, rel_a;
    logic lvl_b, prs_b, rel_b;

    key_debounce #(.DEB_CYCLES(8), .ACTIVE_LOW(1'b1)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .key_in      (key_a),
        .key_level   (lvl_a),
        .key_press   (prs_a),
        .key_release (rel_a)
    );

    key_debounce #(.DEB_CYCLES(2), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .key_in      (key_b),
        .key_level   (lvl_b),
        .key_press   (prs_b),
        .key_release (rel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: a level is accepted once the pressed-normalised pin,
    // as seen two edges after capture, has disagreed with the current
    // debounced level on DEB+1 consecutive edges.
    int   m_deb [2] = '{8, 2};
    bit   m_al  [2] = '{1'b1, 1'b0};
    logic m_h1  [2];
    logic m_h2  [2];
    logic m_lvl [2];
    logic m_prs [2];
    logic m_rel [2];
    int   m_run [2];

    task automatic model_step(input int i, input logic rst, input logic kin);
        logic ks;
        if (!rst) begin
            m_h1[i]  = m_al[i];
            m_h2[i]  = m_al[i];
            m_lvl[i] = 1'b0;
            m_prs[i] = 1'b0;
            m_rel[i] = 1'b0;
            m_run[i] = 0;
        end else begin
            ks       = m_h2[i] ^ m_al[i];
            m_prs[i] = 1'b0;
            m_rel[i] = 1'b0;
            if (ks != m_lvl[i]) m_run[i] = m_run[i] + 1;
            else                m_run[i] = 0;
            if (m_run[i] == m_deb[i] + 1) begin
                m_lvl[i] = ks;
                m_prs[i] = ks;
                m_rel[i] = ~ks;
                m_run[i] = 0;
            end
            m_h2[i] = m_h1[i];
            m_h1[i] = kin;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    int   pa_cnt, ra_cnt, pb_cnt;
    int   pa_cyc, ra_cyc, pb_cyc, fall_a_cyc;
    logic lvl_a_prev;

    always @(posedge clk) begin
        cyc++;
        model_step(0, rst_a_n, key_a);
        model_step(1, rst_b_n, key_b);
        #1;
        chk("a_level",   lvl_a, m_lvl[0]);
        chk("a_press",   prs_a, m_prs[0]);
        chk("a_release", rel_a, m_rel[0]);
        chk("b_level",   lvl_b, m_lvl[1]);
        chk("b_press",   prs_b, m_prs[1]);
        chk("b_release", rel_b, m_rel[1]);
        if (prs_a === 1'b1) begin pa_cnt++; pa_cyc = cyc; end
        if (rel_a === 1'b1) begin ra_cnt++; ra_cyc = cyc; end
        if (prs_b === 1'b1) begin pb_cnt++; pb_cyc = cyc; end
        if (lvl_a_prev === 1'b1 && lvl_a === 1'b0) fall_a_cyc = cyc;
        lvl_a_prev = lvl_a;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        pa_cnt = 0; ra_cnt = 0; pb_cnt = 0;
        pa_cyc = -1; ra_cyc = -1; pb_cyc = -1; fall_a_cyc = -1;
    endtask

    int t0, d, hold_a, hold_b;

    initial begin
        clr();
        lvl_a_prev = 1'b0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        key_a = 1'b1; key_b = 1'b0;
        wait_n(3);
        chk("rst_a_level", lvl_a, 0);
        chk("rst_a_press", prs_a, 0);
        chk("rst_b_level", lvl_b, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        wait_n(5);

        // clean press
        clr();
        key_a = 1'b0; t0 = cyc + 1;
        wait_n(20);
        chk("t1_press_edge", pa_cyc, t0 + 10);
        chk("t1_press_count", pa_cnt, 1);
        chk("t1_level", lvl_a, 1);
        chk("t1_release_count", ra_cnt, 0);
        key_a = 1'b1;
        wait_n(20);

        // bounce during press
        clr();
        key_a = 1'b0; wait_n(3);
        key_a = 1'b1; wait_n(2);
        key_a = 1'b0; t0 = cyc + 1;
        wait_n(20);
        chk("t2_press_edge", pa_cyc, t0 + 10);
        chk("t2_press_count", pa_cnt, 1);
        key_a = 1'b1;
        wait_n(20);

        // glitch rejection
        clr();
        key_a = 1'b0; wait_n(7);
        key_a = 1'b1; wait_n(20);
        chk("t3_press_count", pa_cnt, 0);
        chk("t3_release_count", ra_cnt, 0);
        chk("t3_level", lvl_a, 0);

        // full press and release with release bounce
        clr();
        key_a = 1'b0; wait_n(50);
        chk("t4_level_pressed", lvl_a, 1);
        key_a = 1'b1; wait_n(1);
        key_a = 1'b0; wait_n(1);
        key_a = 1'b1; wait_n(1);
        key_a = 1'b0; wait_n(1);
        key_a = 1'b1; t0 = cyc + 1;
        wait_n(20);
        chk("t4_press_count", pa_cnt, 1);
        chk("t4_release_count", ra_cnt, 1);
        chk("t4_release_edge", ra_cyc, t0 + 10);
        chk("t4_level_fall_edge", fall_a_cyc, t0 + 10);

        // reset mid-filter, counter at 5
        clr();
        key_a = 1'b0; t0 = cyc + 1;
        wait_n(8);
        rst_a_n = 1'b0;
        #1;
        chk("t5_level_in_reset", lvl_a, 0);
        chk("t5_press_in_reset", prs_a, 0);
        wait_n(3);
        rst_a_n = 1'b1; d = cyc + 1;
        wait_n(15);
        chk("t5_press_count", pa_cnt, 1);
        chk("t5_press_edge", pa_cyc, d + 10);
        key_a = 1'b1;
        wait_n(20);

        // active-high pin, short filter
        clr();
        rst_b_n = 1'b0; key_b = 1'b0;
        wait_n(3);
        rst_b_n = 1'b1;
        wait_n(10);
        chk("t6_no_spurious", pb_cnt, 0);
        key_b = 1'b1; t0 = cyc + 1;
        wait_n(10);
        chk("t6_press_edge", pb_cyc, t0 + 4);
        chk("t6_press_count", pb_cnt, 1);
        chk("t6_level", lvl_b, 1);
        key_b = 1'b0;
        wait_n(10);

        // randomized bouncing pins with occasional resets
        hold_a = 0; hold_b = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold_a == 0) begin
                key_a  = ~key_a;
                hold_a = $urandom_range(1, 14);
            end else begin
                hold_a--;
            end
            if (hold_b == 0) begin
                key_b  = ~key_b;
                hold_b = $urandom_range(1, 4);
            end else begin
                hold_b--;
            end
            rst_a_n = ($urandom_range(0, 299) != 0);
            rst_b_n = ($urandom_range(0, 299) != 0);
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        wait_n(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
